// File: rtl/spi_master_param_if.sv
// rtl/spi_master_param_if.sv - command/status bus and SPI pins of the parametrised SPI master
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int NCS    = 1
) ();
    logic              load;
    logic [DATA_W+7:0] in;
    logic [DATA_W+7:0] out;
    logic [NCS-1:0]    csx;
    logic              sdo;
    logic              sdi;
    logic              sck;

    modport master (input load, in, sdi, output out, csx, sdo, sck);
    modport slave  (output load, in, sdi, input out, csx, sdo, sck);
endinterface

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised full-duplex SPI master with chip selects and done/overrun status
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int DIV    = 1,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0,
    parameter int NCS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_param_if.master bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W);

    logic [0:0]        state;
    logic [CW-1:0]     div_cnt;
    logic [EW-1:0]     edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] rx;
    logic              done;
    logic              overrun;
    logic              sck_r;
    logic [NCS-1:0]    csx_r;

    logic [DATA_W-1:0] cmd_tx;
    logic              cmd_cs_only;
    logic [1:0]        cmd_cs_sel;
    logic              unused_rsvd;

    assign cmd_tx      = bus.in[DATA_W-1:0];
    assign cmd_cs_only = bus.in[DATA_W];
    assign cmd_cs_sel  = bus.in[DATA_W+2:DATA_W+1];
    assign unused_rsvd = ^bus.in[DATA_W+7:DATA_W+3];

    logic              busy;
    logic              tick;
    logic [EW-1:0]     edge_nxt;
    logic              leading;
    logic              last_edge;
    logic              sample_now;
    logic              shift_now;
    logic [DATA_W-1:0] rx_next;
    logic [NCS-1:0]    cs_dec;

    assign busy      = (state == XFER);
    assign tick      = busy && (div_cnt == DIV_LAST);
    assign edge_nxt  = edge_cnt + 1'b1;
    assign leading   = edge_nxt[0];
    assign last_edge = (edge_nxt == EDGE_LAST);
    // Sample on the leading edge in CPHA=0, trailing in CPHA=1; shift on the other one.
    assign sample_now = leading ^ CPHA;
    assign shift_now  = !sample_now && !last_edge && !(CPHA && edge_nxt == EW'(1));
    assign rx_next    = {rx_sh[DATA_W-2:0], bus.sdi};

    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NCS; i++) begin
            if (int'(cmd_cs_sel) == i) cs_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx       <= '0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            sck_r    <= CPOL;
            csx_r    <= '1;
        end else begin
            if (bus.load && busy) overrun <= 1'b1;

            if (bus.load && !busy) begin
                done    <= 1'b0;
                overrun <= 1'b0;
                if (cmd_cs_only) begin
                    csx_r <= '1;
                end else begin
                    csx_r    <= cs_dec;
                    tx_sh    <= cmd_tx;
                    rx_sh    <= '0;
                    state    <= XFER;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    sck_r    <= CPOL;
                end
            end else if (busy) begin
                if (tick) begin
                    div_cnt <= '0;
                    if (last_edge) begin
                        // The final edge in CPHA=1 is also the last sample point.
                        state <= IDLE;
                        sck_r <= CPOL;
                        done  <= 1'b1;
                        rx    <= sample_now ? rx_next : rx_sh;
                    end else begin
                        sck_r    <= ~sck_r;
                        edge_cnt <= edge_nxt;
                        if (sample_now) rx_sh <= rx_next;
                        if (shift_now)  tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.sck = sck_r;
    assign bus.csx = csx_r;
    assign bus.sdo = busy & tx_sh[DATA_W-1];
    assign bus.out = {busy, overrun, done, 5'b0, rx};
endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - randomized scoreboard bench for spi_master_param (mode 3, DIV=3, NCS=3)
module tb_spi_master_param;
    localparam int DW   = 8;
    localparam int DIV  = 3;
    localparam int NCS  = 3;
    localparam bit CPOL = 1'b1;
    localparam bit CPHA = 1'b1;
    localparam int XLEN = 2 * DW * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_param_if #(.DATA_W(DW), .NCS(NCS)) bus ();

    spi_master_param #(
        .DATA_W(DW), .DIV(DIV), .CPOL(CPOL), .CPHA(CPHA), .NCS(NCS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [DW-1:0]  tx;
        logic [DW-1:0]  rx;
        logic [NCS-1:0] csx;
        bit             ovr;
    } exp_t;

    exp_t sbq[$];
    int tests = 0;
    int fails = 0;
    bit abort = 1'b0;
    logic [DW-1:0] last_rx = '0;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCS-1:0] csx_for(int sel);
        logic [NCS-1:0] v;
        for (int i = 0; i < NCS; i++) v[i] = (i != sel);
        return v;
    endfunction

    // Monitor plus behavioural SPI slave: serves the expected rx word and records MOSI.
    initial begin
        logic prev_sck, prev_sdo, prev_busy, busy;
        int edges, cycles, trail;
        logic [DW-1:0] slave_word, mosi;
        exp_t cur;
        prev_sck = CPOL; prev_sdo = 1'b0; prev_busy = 1'b0;
        edges = 0; cycles = 0; trail = 0; slave_word = '0; mosi = '0;
        bus.sdi = 1'b0;
        forever begin
            @(negedge clk);
            busy = bus.out[DW+7];
            if (!rst_n || abort) begin
                prev_busy = 1'b0; prev_sck = bus.sck; prev_sdo = bus.sdo;
                continue;
            end
            if (prev_busy && bus.sck != prev_sck) begin
                edges++;
                if (bus.sck == CPOL) begin
                    mosi = {mosi[DW-2:0], prev_sdo};
                    trail++;
                    if (trail < DW) bus.sdi = slave_word[DW-1-trail];
                end
            end
            if (busy && !prev_busy) begin
                edges = 0; cycles = 0; trail = 0; mosi = '0;
                if (sbq.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    cur = sbq[0];
                    slave_word = cur.rx;
                    check("csx_at_start", bus.csx, cur.csx);
                    check("sdo_first_bit", bus.sdo, cur.tx[DW-1]);
                end
                bus.sdi = slave_word[DW-1];
            end
            if (busy) cycles++;
            if (!busy && prev_busy) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    cur = sbq.pop_front();
                    check("rx_data", bus.out[DW-1:0], cur.rx);
                    check("done_flag", bus.out[DW+5], 1);
                    check("overrun_flag", bus.out[DW+6], cur.ovr);
                    check("csx_held", bus.csx, cur.csx);
                    check("mosi_word", mosi, cur.tx);
                    check("sck_edges", edges, 2 * DW);
                    check("busy_cycles", cycles, XLEN);
                    check("sck_idle", bus.sck, CPOL);
                    check("sdo_idle", bus.sdo, 0);
                    last_rx = cur.rx;
                end
            end
            prev_busy = busy; prev_sck = bus.sck; prev_sdo = bus.sdo;
        end
    end

    task automatic send(logic [DW+7:0] cmd);
        bus.in = cmd;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        bus.in = (DW+8)'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.out[DW+7] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", bus.out[DW+7], 0);
    endtask

    task automatic xfer(logic [DW-1:0] tx, int sel, logic [DW-1:0] slave, int reject_at);
        exp_t e;
        e.tx = tx; e.rx = slave; e.csx = csx_for(sel); e.ovr = (reject_at != 0);
        sbq.push_back(e);
        send({5'($urandom), 2'(sel), 1'b0, tx});
        if (reject_at != 0) begin
            repeat (reject_at - 1) @(negedge clk);
            send((DW+8)'($urandom));
        end
        wait_idle();
        if (reject_at != 0) begin
            @(negedge clk);
            check("overrun_sticky", bus.out[DW+6], 1);
            check("done_after_reject", bus.out[DW+5], 1);
        end
    endtask

    task automatic cs_only();
        logic s0;
        int changes = 0;
        send({5'($urandom), 2'($urandom), 1'b1, DW'($urandom)});
        s0 = bus.sck;
        repeat (6) begin
            @(negedge clk);
            if (bus.sck != s0) changes++;
        end
        check("cs_only_csx", bus.csx, {NCS{1'b1}});
        check("cs_only_sck_quiet", changes, 0);
        check("cs_only_busy", bus.out[DW+7], 0);
        check("cs_only_done", bus.out[DW+5], 0);
        check("cs_only_ovr", bus.out[DW+6], 0);
        check("cs_only_rx_held", bus.out[DW-1:0], last_rx);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.load = 1'b0;
        bus.in = '0;
        repeat (3) @(negedge clk);
        check("reset_csx", bus.csx, {NCS{1'b1}});
        check("reset_sck", bus.sck, CPOL);
        check("reset_sdo", bus.sdo, 0);
        check("reset_out", bus.out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(8'hA5, 2, 8'h3C, 0);
        xfer(8'h81, 0, 8'h7E, 0);
        xfer(8'hFF, 3, 8'h00, 0);
        cs_only();
        xfer(8'h5A, 1, 8'hC3, 10);
        xfer(8'h12, 0, 8'h34, XLEN);
        xfer(8'h01, 1, 8'h80, 0);
        for (int t = 0; t < 16; t++) begin
            int rej;
            rej = ($urandom_range(0, 2) == 0) ? $urandom_range(1, XLEN) : 0;
            if ($urandom_range(0, 4) == 0) cs_only();
            xfer(DW'($urandom), $urandom_range(0, 3), DW'($urandom), rej);
        end
        check("scoreboard_empty", sbq.size(), 0);

        begin
            exp_t e;
            e.tx = 8'hC6; e.rx = 8'h99; e.csx = csx_for(1); e.ovr = 1'b0;
            sbq.push_back(e);
            send({5'b0, 2'd1, 1'b0, 8'hC6});
            repeat (9) @(negedge clk);
            abort = 1'b1;
            rst_n = 1'b0;
            #1;
            check("abort_sck", bus.sck, CPOL);
            check("abort_csx", bus.csx, {NCS{1'b1}});
            check("abort_sdo", bus.sdo, 0);
            check("abort_out", bus.out, 0);
            sbq.delete();
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            abort = 1'b0;
            check("after_abort_out", bus.out, 0);
            check("after_abort_csx", bus.csx, {NCS{1'b1}});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
